// File: rtl/iob_timer_core_if.sv
// Timer control/sample bundle shared between a bus front-end and the timer core.
`timescale 1ns/1ps
interface iob_timer_core_if #(
  parameter int DATA_W = 32
);
  logic              TIMER_ENABLE;
  logic              TIMER_RESET;
  logic              TIMER_SAMPLE;
  logic [2*DATA_W-1:0] TIMER_VALUE;

  modport master (
    output TIMER_ENABLE,
    output TIMER_RESET,
    output TIMER_SAMPLE,
    input  TIMER_VALUE
  );

  modport slave (
    input  TIMER_ENABLE,
    input  TIMER_RESET,
    input  TIMER_SAMPLE,
    output TIMER_VALUE
  );
endinterface

// File: rtl/iob_timer_core.sv
// Free-running 2*DATA_W counter with soft clear and a level-sensitive
// sample register; cke_i gates all state.
`timescale 1ns/1ps
module iob_timer_core #(
  parameter int DATA_W = 32
) (
  input  logic            clk_i,
  input  logic            arst_n_i,
  input  logic            cke_i,
  iob_timer_core_if.slave bus
);
  localparam int CW = 2 * DATA_W;

  logic [CW-1:0] cnt;
  logic [CW-1:0] value;

  // Sample sees the pre-edge count even when cnt clears or steps.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      cnt   <= '0;
      value <= '0;
    end else if (cke_i) begin
      if (bus.TIMER_SAMPLE)
        value <= cnt;
      if (bus.TIMER_RESET)
        cnt <= '0;
      else if (bus.TIMER_ENABLE)
        cnt <= cnt + 1'b1;
    end
  end

  assign bus.TIMER_VALUE = value;
endmodule

// File: tb/tb_iob_timer_core.sv
// Directed checks for iob_timer_core: timing, gating, clear,
// wrap, clock enable, hold and async reset.
`timescale 1ns/1ps
module tb_iob_timer_core;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic cke = 1'b1;
  int   n_chk = 0;
  int   n_ok = 0;

  always #5 clk = ~clk;

  iob_timer_core_if #(.DATA_W(32)) b ();
  iob_timer_core_if #(.DATA_W(4))  s ();

  iob_timer_core #(.DATA_W(32)) dut (
    .clk_i   (clk),
    .arst_n_i(arst_n),
    .cke_i   (cke),
    .bus     (b.slave)
  );

  iob_timer_core #(.DATA_W(4)) dut_s (
    .clk_i   (clk),
    .arst_n_i(arst_n),
    .cke_i   (cke),
    .bus     (s.slave)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_ok++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    b.TIMER_ENABLE = 1'b0;
    b.TIMER_RESET  = 1'b0;
    b.TIMER_SAMPLE = 1'b0;
    s.TIMER_ENABLE = 1'b0;
    s.TIMER_RESET  = 1'b0;
    s.TIMER_SAMPLE = 1'b0;

    #2;
    check("rst_val", b.TIMER_VALUE, 64'd0);
    check("rst_val_s", {56'd0, s.TIMER_VALUE}, 64'd0);
    b.TIMER_SAMPLE = 1'b1;
    b.TIMER_ENABLE = 1'b1;
    tick(2);
    check("rst_hold", b.TIMER_VALUE, 64'd0);
    b.TIMER_SAMPLE = 1'b0;
    b.TIMER_ENABLE = 1'b0;

    // baseline timing
    arst_n = 1'b1;
    tick(1);
    b.TIMER_ENABLE = 1'b1;
    tick(1);
    b.TIMER_SAMPLE = 1'b1;
    tick(1);
    check("first_sample", b.TIMER_VALUE, 64'd1);
    b.TIMER_SAMPLE = 1'b0;
    tick(1001);
    b.TIMER_SAMPLE = 1'b1;
    tick(1);
    check("sample_1003", b.TIMER_VALUE, 64'd1003);
    b.TIMER_SAMPLE = 1'b0;

    // enable gating
    b.TIMER_ENABLE = 1'b0;
    b.TIMER_RESET  = 1'b1;
    tick(1);
    b.TIMER_RESET  = 1'b0;
    b.TIMER_ENABLE = 1'b1;
    tick(50);
    b.TIMER_ENABLE = 1'b0;
    tick(20);
    b.TIMER_SAMPLE = 1'b1;
    tick(1);
    check("gate_50", b.TIMER_VALUE, 64'd50);
    b.TIMER_SAMPLE = 1'b0;

    // soft clear, with same-edge sample
    b.TIMER_RESET = 1'b1;
    tick(1);
    b.TIMER_RESET  = 1'b0;
    b.TIMER_ENABLE = 1'b1;
    tick(100);
    b.TIMER_RESET  = 1'b1;
    b.TIMER_SAMPLE = 1'b1;
    tick(1);
    check("clr_pre_edge", b.TIMER_VALUE, 64'd100);
    b.TIMER_RESET  = 1'b0;
    b.TIMER_SAMPLE = 1'b0;
    tick(10);
    b.TIMER_ENABLE = 1'b0;
    b.TIMER_SAMPLE = 1'b1;
    tick(1);
    check("clr_10", b.TIMER_VALUE, 64'd10);

    // level-sensitive sample while counting
    b.TIMER_ENABLE = 1'b1;
    tick(1);
    check("lvl_0", b.TIMER_VALUE, 64'd10);
    tick(1);
    check("lvl_1", b.TIMER_VALUE, 64'd11);
    tick(1);
    check("lvl_2", b.TIMER_VALUE, 64'd12);
    b.TIMER_SAMPLE = 1'b0;

    // hold for 500 cycles, counter still running
    for (int i = 1; i <= 500; i++) begin
      tick(1);
      if (i % 50 == 0) check("hold", b.TIMER_VALUE, 64'd12);
    end

    // clock enable freeze: cnt is 513 here
    tick(20);
    cke = 1'b0;
    b.TIMER_SAMPLE = 1'b1;
    tick(15);
    b.TIMER_RESET = 1'b1;
    tick(15);
    check("cke_val_frozen", b.TIMER_VALUE, 64'd12);
    b.TIMER_RESET  = 1'b0;
    b.TIMER_ENABLE = 1'b0;
    cke = 1'b1;
    tick(1);
    check("cke_cnt_frozen", b.TIMER_VALUE, 64'd533);
    b.TIMER_SAMPLE = 1'b0;

    // wrap-around on the 8-bit counter
    s.TIMER_RESET = 1'b1;
    tick(1);
    s.TIMER_RESET  = 1'b0;
    s.TIMER_ENABLE = 1'b1;
    tick(256);
    s.TIMER_ENABLE = 1'b0;
    s.TIMER_SAMPLE = 1'b1;
    tick(1);
    check("wrap_256", {56'd0, s.TIMER_VALUE}, 64'd0);
    s.TIMER_SAMPLE = 1'b0;
    s.TIMER_RESET  = 1'b1;
    tick(1);
    s.TIMER_RESET  = 1'b0;
    s.TIMER_ENABLE = 1'b1;
    tick(255);
    s.TIMER_ENABLE = 1'b0;
    s.TIMER_SAMPLE = 1'b1;
    tick(1);
    check("wrap_255", {56'd0, s.TIMER_VALUE}, 64'd255);
    s.TIMER_SAMPLE = 1'b0;

    // async reset between edges, then resume from zero
    b.TIMER_ENABLE = 1'b1;
    tick(5);
    arst_n = 1'b0;
    #2;
    check("arst_now", b.TIMER_VALUE, 64'd0);
    check("arst_now_s", {56'd0, s.TIMER_VALUE}, 64'd0);
    tick(2);
    arst_n = 1'b1;
    tick(7);
    b.TIMER_ENABLE = 1'b0;
    b.TIMER_SAMPLE = 1'b1;
    tick(1);
    check("arst_resume", b.TIMER_VALUE, 64'd7);
    b.TIMER_SAMPLE = 1'b0;

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule

// File: doc/iob_timer_core.md
IOB_TIMER_CORE -- requirements
Module: iob_timer_core

Interface
REQ-001 Parameter DATA_W, default 32; sets the bus word width; counter and sample register are 2*DATA_W bits.
REQ-002 clk_i  input  1  single system clock; all state updates on rising edge.
REQ-003 arst_n_i  input  1  asynchronous, active-low reset.
REQ-004 cke_i  input  1  clock enable; when low, all internal state holds.
REQ-005 TIMER_ENABLE  input  1  count enable; counter increments while high.
REQ-006 TIMER_RESET  input  1  synchronous soft clear of the free-running counter.
REQ-007 TIMER_SAMPLE  input  1  captures the counter into TIMER_VALUE.
REQ-008 TIMER_VALUE  output  2*DATA_W  registered sampled counter value.

Function
REQ-009 Internal counter cnt, 2*DATA_W bits, unsigned, not directly visible at the ports.
REQ-010 On a rising edge with cke_i=1 and TIMER_RESET=1, cnt becomes 0, regardless of TIMER_ENABLE.
REQ-011 On a rising edge with cke_i=1, TIMER_RESET=0 and TIMER_ENABLE=1, cnt becomes cnt+1; no enable pipeline delay.
REQ-012 With TIMER_ENABLE=0 and TIMER_RESET=0, cnt holds.
REQ-013 Counter wraps modulo 2^(2*DATA_W): all-ones increments to 0, with no flag or saturation.
REQ-014 On a rising edge with cke_i=1 and TIMER_SAMPLE=1, TIMER_VALUE takes the pre-edge value of cnt; 1-cycle latency from sample to output.
REQ-015 When TIMER_SAMPLE=0, TIMER_VALUE holds its last captured value indefinitely.
REQ-016 When sample and soft reset or increment occur in the same cycle, TIMER_VALUE receives the pre-edge cnt, and cnt updates per REQ-010/011 on the same edge.
REQ-017 cke_i=0 freezes both cnt and TIMER_VALUE, whatever the other inputs.
REQ-018 TIMER_SAMPLE is level-sensitive: holding it high for N cycles captures on every one of those edges.
REQ-019 No combinational path from any input to TIMER_VALUE.

Reset
REQ-020 When arst_n_i=0, cnt=0 and TIMER_VALUE=0 immediately, independent of clk_i and cke_i.
REQ-021 Reset release is synchronous-safe: the first edge after deassertion obeys REQ-010..018 normally.
REQ-022 Asserting reset mid-count discards the count; counting resumes from 0 after release if TIMER_ENABLE=1.

Verification
REQ-023 Baseline timing, 10 ns clock:
- Sequence: reset; release at edge 0; ENABLE=1 after edge 1; SAMPLE pulse 1 cycle after edge 2.
- TIMER_VALUE=1 after edge 3.
- Wait 1000 clock periods, then pulse SAMPLE for one cycle.
- TIMER_VALUE=1003 after the capturing edge.
REQ-024 Enable gating: ENABLE=1 for 50 cycles, then 0 for 20 cycles, then sample -> TIMER_VALUE=50.
REQ-025 Soft clear: count to 100; TIMER_RESET=1 for one cycle with ENABLE=1; 10 more cycles; sample -> TIMER_VALUE=10.
REQ-026 Wrap-around, DATA_W=4: 256 enabled cycles -> sample gives 0; 255 enabled cycles -> sample gives 255.
REQ-027 cke_i and hold:
- cke_i=0 for 30 cycles mid-count -> count is unchanged across that window.
- SAMPLE=0 for 500 cycles -> TIMER_VALUE is stable.
REQ-028 Async reset: assert arst_n_i low between clock edges -> TIMER_VALUE reads 0 before the next rising edge.
